// File: rtl/multicycle_accum.sv
// ---------------------------------------------------------------------------
// multicycle_accum
//
// Multicycle signed add/subtract accumulator. An accepted start loads the
// accumulator with init_val and snapshots the operands and add/sub mask.
// The block then applies one operand per clock for NUM_OPS clocks. After
// that it presents the final value together with a sticky signed-overflow
// flag and raises a one-cycle done pulse.
//
// Parameters
//   WIDTH    : data width, two's-complement signed (>= 2)
//   NUM_OPS  : operands per operation (>= 1)
//   SATURATE : 0 = wrap modulo 2^WIDTH, 1 = clamp each step to max/min
//
// Ports
//   clock    : rising-edge clock
//   reset    : synchronous, active-high; aborts any operation in flight
//   start    : request a new operation (honoured only in IDLE or DONE)
//   init_val : starting accumulator value, captured on accepted start
//   ops      : flattened operands, operand i = ops[i*WIDTH +: WIDTH]
//   op_mask  : bit i = 1 adds operand i, 0 subtracts it
//   busy     : high while accumulating
//   done     : one-cycle pulse when result/overflow are updated
//   result   : final value of the last completed operation
//   overflow : some step of the last completed operation overflowed
// ---------------------------------------------------------------------------
module multicycle_accum #(
  parameter int WIDTH    = 8,
  parameter int NUM_OPS  = 3,
  parameter int SATURATE = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         init_val,
  input  logic [NUM_OPS*WIDTH-1:0] ops,
  input  logic [NUM_OPS-1:0]       op_mask,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     overflow
);

  localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]               state;
  logic [WIDTH-1:0]         acc;
  logic [NUM_OPS*WIDTH-1:0] ops_q;
  logic [NUM_OPS-1:0]       mask_q;
  logic [IDX_W-1:0]         idx;
  logic                     ovf_acc;

  logic [WIDTH-1:0] cur_op;
  logic             cur_add;
  logic [WIDTH:0]   sum_ext;
  logic             step_ovf;
  logic [WIDTH-1:0] step_val;

  // One accumulation step. The operand is picked with a compare-per-slot
  // mux so that no out-of-range part-select is ever formed when NUM_OPS is
  // not a power of two. The sum is formed one bit wider than the data. The
  // two top bits of that wider sum disagree exactly when the signed result
  // does not fit in WIDTH bits. Bit WIDTH is the true sign, so it tells us
  // which rail to clamp to.
  always_comb begin
    cur_op  = '0;
    cur_add = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (idx == i[IDX_W-1:0]) begin
        cur_op  = ops_q[i*WIDTH +: WIDTH];
        cur_add = mask_q[i];
      end
    end

    if (cur_add) begin
      sum_ext = {acc[WIDTH-1], acc} + {cur_op[WIDTH-1], cur_op};
    end else begin
      sum_ext = {acc[WIDTH-1], acc} - {cur_op[WIDTH-1], cur_op};
    end

    step_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
    step_val = sum_ext[WIDTH-1:0];
    if ((SATURATE != 0) && step_ovf) begin
      step_val = sum_ext[WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  // Control and datapath registers. busy and done are kept as their own
  // flops, so every output comes straight from a register. A start seen in
  // DONE is treated exactly like one seen in IDLE, which allows
  // back-to-back operations. result and overflow are written only on the
  // final step, so they hold steady between completions.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      acc      <= '0;
      ops_q    <= '0;
      mask_q   <= '0;
      idx      <= '0;
      ovf_acc  <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc     <= init_val;
            ops_q   <= ops;
            mask_q  <= op_mask;
            idx     <= '0;
            ovf_acc <= 1'b0;
            state   <= S_ACCUM;
            busy    <= 1'b1;
            done    <= 1'b0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        S_ACCUM: begin
          acc     <= step_val;
          ovf_acc <= ovf_acc | step_ovf;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state    <= S_DONE;
            result   <= step_val;
            overflow <= ovf_acc | step_ovf;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            busy <= 1'b1;
            done <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_accum.sv
// ---------------------------------------------------------------------------
// tb_multicycle_accum
//
// Self-checking bench for multicycle_accum. Two 8-bit, 3-operand instances
// share one stimulus stream: one wraps and one saturates. A third instance
// with NUM_OPS=1 covers the single-step case. Expected values come from a
// plain integer model of the arithmetic rules.
// ---------------------------------------------------------------------------
module tb_multicycle_accum;

  localparam int W = 8;
  localparam int N = 3;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic [W-1:0]   init_val;
  logic [N*W-1:0] ops;
  logic [N-1:0]   op_mask;

  logic busy_w, done_w, ovf_w;
  logic [W-1:0] res_w;
  logic busy_s, done_s, ovf_s;
  logic [W-1:0] res_s;

  logic         start1;
  logic [W-1:0] init1;
  logic [W-1:0] ops1;
  logic [0:0]   mask1;
  logic         busy1, done1, ovf1;
  logic [W-1:0] res1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  multicycle_accum #(.WIDTH(W), .NUM_OPS(N), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset(reset), .start(start), .init_val(init_val),
    .ops(ops), .op_mask(op_mask), .busy(busy_w), .done(done_w),
    .result(res_w), .overflow(ovf_w)
  );

  multicycle_accum #(.WIDTH(W), .NUM_OPS(N), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .init_val(init_val),
    .ops(ops), .op_mask(op_mask), .busy(busy_s), .done(done_s),
    .result(res_s), .overflow(ovf_s)
  );

  multicycle_accum #(.WIDTH(W), .NUM_OPS(1), .SATURATE(0)) dut_one (
    .clock(clock), .reset(reset), .start(start1), .init_val(init1),
    .ops(ops1), .op_mask(mask1), .busy(busy1), .done(done1),
    .result(res1), .overflow(ovf1)
  );

  // Reference arithmetic. Each step is done in plain integers, range-checked
  // against the signed 8-bit limits, then clamped or folded back into range.
  function automatic void model(input int init, input int a, input int b,
                                input int c, input logic [2:0] m, input bit sat,
                                output logic [7:0] r, output bit ov);
    int acc;
    int opv[3];
    opv[0] = a;
    opv[1] = b;
    opv[2] = c;
    acc = init;
    ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc = m[i] ? acc + opv[i] : acc - opv[i];
      if (acc > 127 || acc < -128) begin
        ov = 1'b1;
        if (sat) acc = (acc > 127) ? 127 : -128;
        else     acc = ((acc % 256) + 256 + 128) % 256 - 128;
      end
    end
    r = acc[7:0];
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_inputs(input int i, input int a, input int b, input int c,
                            input logic [2:0] m);
    init_val = i[7:0];
    ops      = {c[7:0], b[7:0], a[7:0]};
    op_mask  = m;
  endtask

  // Drive a one-cycle start. Returns just after the accepting edge.
  task automatic launch(input int i, input int a, input int b, input int c,
                        input logic [2:0] m);
    set_inputs(i, a, b, c, m);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done on the shared-stimulus pair. cyc = -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (done_w) begin
        cyc = k;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    set_inputs(0, 0, 0, 0, 3'b000);
    init1 = '0;
    ops1 = '0;
    mask1 = '0;
    tick();
    tick();
    n_cmp++;
    if ({busy_w, done_w, ovf_w, res_w} !== 11'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_wrap: got %b expected 0", {busy_w, done_w, ovf_w, res_w});
    end
    n_cmp++;
    if ({busy_s, done_s, ovf_s, res_s} !== 11'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_sat: got %b expected 0", {busy_s, done_s, ovf_s, res_s});
    end
    n_cmp++;
    if ({busy1, done1, ovf1, res1} !== 11'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_one: got %b expected 0", {busy1, done1, ovf1, res1});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    launch(10, 5, 3, 2, 3'b101);
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (busy_w !== 1'b1 || done_w !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL basic_busy[%0d]: got busy=%b done=%b expected busy=1 done=0",
                 k, busy_w, done_w);
      end
      tick();
    end
    n_cmp++;
    if (done_w !== 1'b1 || busy_w !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL basic_done_latency: got done=%b busy=%b expected done=1 busy=0",
               done_w, busy_w);
    end
    n_cmp++;
    if (res_w !== 8'd14 || ovf_w !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL basic_result: got %0d/%b expected 14/0", $signed(res_w), ovf_w);
    end
    tick();
    tick();
    n_cmp++;
    if (res_w !== 8'd14 || done_w !== 1'b0 || busy_w !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL basic_hold: got res=%0d done=%b busy=%b expected 14/0/0",
               $signed(res_w), done_w, busy_w);
    end
  endtask

  task automatic test_wrap_sat();
    int cyc;
    launch(100, 50, 0, 0, 3'b111);
    wait_done(cyc);
    n_cmp++;
    if (cyc != 3) begin
      n_bad++;
      $display("[TB] FAIL wrap_latency: got %0d expected 3", cyc);
    end
    n_cmp++;
    if (res_w !== 8'h96 || ovf_w !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL wrap_result: got %h/%b expected 96/1", res_w, ovf_w);
    end
    n_cmp++;
    if (res_s !== 8'd127 || ovf_s !== 1'b1 || done_s !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL sat_pos_result: got %0d/%b done=%b expected 127/1 done=1",
               $signed(res_s), ovf_s, done_s);
    end
    tick();
  endtask

  task automatic test_sat_negative();
    int cyc;
    logic [7:0] r;
    bit ov;
    launch(-100, 50, 10, 0, 3'b000);
    wait_done(cyc);
    n_cmp++;
    if (res_s !== 8'h80 || ovf_s !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL sat_neg_result: got %0d/%b expected -128/1", $signed(res_s), ovf_s);
    end
    model(-100, 50, 10, 0, 3'b000, 1'b0, r, ov);
    n_cmp++;
    if (res_w !== r || ovf_w !== ov) begin
      n_bad++;
      $display("[TB] FAIL wrap_neg_result: got %0d/%b expected %0d/%b",
               $signed(res_w), ovf_w, $signed(r), ov);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    set_inputs(100, 50, 0, 0, 3'b111);
    start = 1'b1;
    tick();
    wait_done(cyc);
    n_cmp++;
    if (cyc != 3 || res_w !== 8'h96 || ovf_w !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL b2b_first: got cyc=%0d res=%h ovf=%b expected 3/96/1",
               cyc, res_w, ovf_w);
    end
    set_inputs(10, 5, 3, 2, 3'b101);
    tick();
    n_cmp++;
    if (busy_w !== 1'b1 || done_w !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL b2b_no_idle: got busy=%b done=%b expected 1/0", busy_w, done_w);
    end
    set_inputs(rnd8(), rnd8(), rnd8(), rnd8(), 3'($urandom_range(7)));
    start = 1'b0;
    wait_done(cyc);
    n_cmp++;
    if (cyc != 3 || res_w !== 8'd14 || ovf_w !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL b2b_second: got cyc=%0d res=%0d ovf=%b expected 3/14/0",
               cyc, $signed(res_w), ovf_w);
    end
    tick();
    n_cmp++;
    if (busy_w !== 1'b0 || done_w !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL b2b_to_idle: got busy=%b done=%b expected 0/0", busy_w, done_w);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, i0, a, b, c;
    logic [2:0] m;
    logic [7:0] r;
    bit ov;
    i0 = rnd8(); a = rnd8(); b = rnd8(); c = rnd8();
    m = 3'($urandom_range(7));
    model(i0, a, b, c, m, 1'b0, r, ov);
    launch(i0, a, b, c, m);
    set_inputs(rnd8(), rnd8(), rnd8(), rnd8(), ~m);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    n_cmp++;
    if (cyc != 2 || res_w !== r || ovf_w !== ov) begin
      n_bad++;
      $display("[TB] FAIL start_ignored: got cyc=%0d res=%0d ovf=%b expected 2/%0d/%b",
               cyc, $signed(res_w), ovf_w, $signed(r), ov);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    bit seen;
    launch(100, 50, 0, 0, 3'b111);
    wait_done(cyc);
    tick();
    launch(10, 5, 3, 2, 3'b101);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (busy_w !== 1'b0 || done_w !== 1'b0 || res_w !== 8'd0 || ovf_w !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_op: got busy=%b done=%b res=%0d ovf=%b expected 0/0/0/0",
               busy_w, done_w, $signed(res_w), ovf_w);
    end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done_w === 1'b1 || done_s === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_no_done: got done seen=%b expected 0", seen);
    end
    launch(10, 5, 3, 2, 3'b101);
    wait_done(cyc);
    n_cmp++;
    if (cyc != 3 || res_w !== 8'd14 || ovf_w !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_recover: got cyc=%0d res=%0d ovf=%b expected 3/14/0",
               cyc, $signed(res_w), ovf_w);
    end
    tick();
  endtask

  task automatic test_single_op();
    int i0, a, e;
    bit ov;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        i0 = -1; a = 1; mask1 = 1'b0;
      end else begin
        i0 = rnd8(); a = rnd8(); mask1 = 1'($urandom_range(1));
      end
      init1 = i0[7:0];
      ops1 = a[7:0];
      e = mask1[0] ? i0 + a : i0 - a;
      ov = (e > 127 || e < -128);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n_cmp++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL single_busy[%0d]: got busy=%b done=%b expected 1/0", k, busy1, done1);
      end
      tick();
      n_cmp++;
      if (done1 !== 1'b1 || res1 !== e[7:0] || ovf1 !== ov) begin
        n_bad++;
        $display("[TB] FAIL single_result[%0d]: got done=%b res=%0d ovf=%b expected 1/%0d/%b",
                 k, done1, $signed(res1), ovf1, $signed(e[7:0]), ov);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int cyc, i0, a, b, c;
    logic [2:0] m;
    logic [7:0] rw, rs;
    bit ow, os;
    for (int k = 0; k < 20; k++) begin
      i0 = rnd8(); a = rnd8(); b = rnd8(); c = rnd8();
      m = 3'($urandom_range(7));
      model(i0, a, b, c, m, 1'b0, rw, ow);
      model(i0, a, b, c, m, 1'b1, rs, os);
      launch(i0, a, b, c, m);
      wait_done(cyc);
      n_cmp++;
      if (cyc != 3 || res_w !== rw || ovf_w !== ow) begin
        n_bad++;
        $display("[TB] FAIL rand_wrap[%0d]: got cyc=%0d res=%0d ovf=%b expected 3/%0d/%b",
                 k, cyc, $signed(res_w), ovf_w, $signed(rw), ow);
      end
      n_cmp++;
      if (done_s !== 1'b1 || res_s !== rs || ovf_s !== os) begin
        n_bad++;
        $display("[TB] FAIL rand_sat[%0d]: got done=%b res=%0d ovf=%b expected 1/%0d/%b",
                 k, done_s, $signed(res_s), ovf_s, $signed(rs), os);
      end
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_sat();
    test_sat_negative();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_op();
    test_single_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
